alu_div_seq: RTL and testbench
==============================

# alu_div_seq

Multi-cycle unsigned divider that acts as the initiator on the 16-bit ALU's operand/op interface. It drives `alu_x`, `alu_y` and `alu_op`, and consumes `alu_res` and `alu_slt` back from the ALU. Division is restoring, one quotient bit per two clock cycles, using only the ALU's subtract path and its SLT flag. It sits beside the ALU in the datapath and lets the core execute divide instructions without a dedicated subtractor.

## Interface
- `W`, 16: operand, quotient and remainder width. Fixed at 16 and must match the ALU width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE.
- `dividend` in 16: unsigned dividend. Bit 15 must be 0.
- `divisor` in 16: unsigned divisor. Bits 15:14 must be 0, and the value must be nonzero.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE state.
- `err` out 1: operand violation flag. Valid while `done`=1 and held until the next accepted start.
- `quotient` out 16: result. Held until the next accepted start.
- `remainder` out 16: result. Held until the next accepted start.
- `alu_op` out 3: driven to ALU op. 3'b100 (sub) in ISSUE/EVAL, 3'b000 otherwise.
- `alu_x` out 16: registered ALU x operand (shifted partial remainder).
- `alu_y` out 16: registered ALU y operand (latched divisor).
- `alu_res` in 16: ALU result, equal to x−y while op=100.
- `alu_slt` in 1: ALU signed x<y flag.

## Operation
- States: IDLE, ISSUE, EVAL, DONE. State register and all outputs reset to 0; state resets to IDLE.
- IDLE, start=1:
  - Latch `dividend` into dvd and `divisor` into `alu_y`.
  - Clear rem, q and `err`.
  - Load bit counter cnt=14.
  - If dividend[15]=1, divisor[15:14]≠0 or divisor=0: set err=1, quotient=16'hFFFF, remainder=dividend, go to DONE.
  - Otherwise go to ISSUE.
- ISSUE:
  - `alu_x` <= {rem[14:0], dvd[cnt]}.
  - `alu_op`=100.
  - Go to EVAL.
- EVAL (ALU outputs are combinational from the registered `alu_x`/`alu_y`; sample them in this cycle):
  - If `alu_slt`=1: q[cnt]=0 and rem <= `alu_x`.
  - Else: q[cnt]=1 and rem <= `alu_res`.
  - If cnt=0: quotient <= final q, remainder <= final rem, go to DONE.
  - Else: cnt <= cnt−1, go to ISSUE.
- DONE: `done`=1, `busy`=1, go to IDLE.
- Width rules:
  - rem < divisor ≤ 16'h3FFF, so the shifted rem is ≤ 16'h7FFD.
  - The ALU's signed SLT is therefore exact for unsigned compare, and sub never overflows. `alu_ov` is not used.
- Quotient bit 15 is always 0. dvd bit 15 is never consumed.
- start while busy is ignored. Operands on the inputs may change freely after acceptance.
- Reset mid-operation aborts immediately: IDLE, all outputs 0, and no `done` pulse.

## Timing
- Cycle 0 is the edge that samples start=1 in IDLE.
- Normal operation:
  - Cycles 1..30 alternate ISSUE/EVAL (15 bits × 2).
  - Cycle 31 is DONE with `done`=1.
  - `quotient`/`remainder` are updated at the edge ending cycle 30 and are valid in cycle 31.
  - IDLE resumes in cycle 32. A new start is accepted in cycle 32 at the earliest, giving a throughput of one divide per 32 cycles.
- Error path: DONE in cycle 1, `done`=1 and `err`=1 in cycle 1, IDLE in cycle 2.
- `busy` is high in cycles 1..31 (1 on the error path).
- `done` is never high for two consecutive cycles.

## Test plan
- dividend=100, divisor=7, start 1 cycle -> `done` exactly in cycle 31, quotient=14, remainder=2, err=0, busy high cycles 1..31.
- dividend=16'h7FFF, divisor=16'h3FFF -> quotient=2, remainder=1. Dividend=5, divisor=9 -> quotient=0, remainder=5. Dividend=0, divisor=1 -> 0/0.
- divisor=0 (and separately divisor=16'h4000, dividend=16'h8000) -> done+err in cycle 1, quotient=16'hFFFF, remainder=dividend, ALU op stays 000.
- start re-asserted with different operands during cycles 1..31 -> ignored, result is from the original operands, exactly one `done`.
- rst asserted asynchronously at cycle 12 -> busy/done/quotient/remainder/alu_* go to 0 immediately. Fresh start after release yields a correct 100/7 result.
- Back-to-back: start in cycle 32 after a completed divide -> second `done` at cycle 63. Outputs hold first result until then.

Source files
------------

// File: rtl/alu_div_seq.sv
// Restoring unsigned divider that borrows the ALU subtract path and SLT flag, one quotient bit per two cycles.
// Latency: done in cycle 31 after the accepting edge (cycle 1 on operand error); one divide per 32 cycles.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped.
module alu_div_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic [2:0]   alu_op,
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    input  logic [W-1:0] alu_res,
    input  logic         alu_slt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] EVAL  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state;
    logic [W-1:0] dvd;
    logic [W-2:0] rem;
    logic [W-1:0] q;
    logic [3:0]   cnt;
    logic         bad_ops;
    logic [W-1:0] rem_nxt;
    logic [W-1:0] q_nxt;

    // rem stays below the divisor (<= 14 bits), so one bit narrower than W suffices.
    assign bad_ops = dividend[W-1] | (|divisor[W-1:W-2]) | ~(|divisor);

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign alu_op = (state == ISSUE || state == EVAL) ? 3'b100 : 3'b000;

    always_comb begin
        rem_nxt    = alu_slt ? alu_x : alu_res;
        q_nxt      = q;
        q_nxt[cnt] = ~alu_slt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dvd       <= '0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= dividend;
                        alu_y <= divisor;
                        rem   <= '0;
                        q     <= '0;
                        err   <= 1'b0;
                        cnt   <= 4'(W - 2);
                        if (bad_ops) begin
                            err       <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            state     <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    alu_x <= {rem, dvd[cnt]};
                    state <= EVAL;
                end
                EVAL: begin
                    rem <= rem_nxt[W-2:0];
                    q   <= q_nxt;
                    if (cnt == 4'd0) begin
                        quotient  <= q_nxt;
                        remainder <= rem_nxt;
                        state     <= DONE;
                    end else begin
                        cnt   <= cnt - 4'd1;
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: behavioural ALU, arithmetic reference model with per-cycle compare, directed and random divides.
// Latency: n/a.  Backpressure: n/a.
module tb_alu_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, err;
    logic [15:0] quotient, remainder;
    logic [2:0]  alu_op;
    logic [15:0] alu_x, alu_y, alu_res;
    logic        alu_slt;

    alu_div_seq #(.W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .err(err),
        .quotient(quotient), .remainder(remainder),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
        .alu_res(alu_res), .alu_slt(alu_slt)
    );

    always #5 clk = ~clk;

    // The 16-bit ALU this divider drives: subtract for op 100, add otherwise, signed less-than flag.
    always_comb begin
        alu_res = (alu_op == 3'b100) ? alu_x - alu_y : alu_x + alu_y;
        alu_slt = ($signed(alu_x) < $signed(alu_y));
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: result of the accepted request and the cycle window it occupies.
    int tick = 0;
    int m_s = -1000;
    int m_done = -1001;
    logic [15:0] m_q = '0, m_r = '0, m_b = '0;
    logic [15:0] p_q = '0, p_r = '0, p_b = '0;
    logic        m_err = 1'b0, p_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s = -1000; m_done = -1001;
            m_q = '0; m_r = '0; m_b = '0; m_err = 1'b0;
            p_q = '0; p_r = '0; p_b = '0; p_err = 1'b0;
        end else begin
            tick++;
            if (start && tick >= m_done + 2) begin
                p_q = m_q; p_r = m_r; p_b = m_b; p_err = m_err;
                m_s = tick;
                m_b = divisor;
                if (dividend[15] || divisor[15:14] != 2'b00 || divisor == 16'd0) begin
                    m_err = 1'b1; m_q = 16'hFFFF; m_r = dividend; m_done = tick;
                end else begin
                    m_err = 1'b0; m_q = dividend / divisor; m_r = dividend % divisor; m_done = tick + 30;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, (tick >= m_s && tick <= m_done));
            check("done", done, (tick == m_done));
            check("alu_op", alu_op, (!m_err && tick >= m_s && tick < m_done) ? 3'b100 : 3'b000);
            check("quotient", quotient, (tick >= m_done) ? m_q : p_q);
            check("remainder", remainder, (tick >= m_done) ? m_r : p_r);
            check("err", err, (tick >= m_done) ? m_err : ((tick >= m_s) ? 1'b0 : p_err));
            check("alu_y", alu_y, (tick >= m_s) ? m_b : p_b);
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_quotient"}, quotient, 0);
        check({tag, "_remainder"}, remainder, 0);
        check({tag, "_alu_op"}, alu_op, 0);
        check({tag, "_alu_x"}, alu_x, 0);
        check({tag, "_alu_y"}, alu_y, 0);
    endtask

    // Called at a negedge with the divider idle; returns at the negedge where done is seen.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ee,
                          input int lat, input bit noise);
        int seen;
        seen = -1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (noise && k >= 3 && k <= 8) begin
                start    = 1'b1;
                dividend = 16'($urandom) & 16'h7FFF;
                divisor  = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = k;
                break;
            end
        end
        check("latency", seen, lat);
        check("lit_quotient", quotient, eq);
        check("lit_remainder", remainder, er);
        check("lit_err", err, ee);
        check("busy_at_done", busy, 1);
    endtask

    int r;

    initial begin
        #1 rst = 1'b1;
        #3 check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 31, 1'b0);
        @(negedge clk);
        run_op(16'h7FFF, 16'h3FFF, 16'd2, 16'd1, 1'b0, 31, 1'b0);
        @(negedge clk);
        run_op(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 31, 1'b0);
        @(negedge clk);
        run_op(16'd0, 16'd1, 16'd0, 16'd0, 1'b0, 31, 1'b0);
        @(negedge clk);
        run_op(16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 1, 1'b0);
        @(negedge clk);
        run_op(16'h8000, 16'h4000, 16'hFFFF, 16'h8000, 1'b1, 1, 1'b0);
        @(negedge clk);
        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 31, 1'b1);
        @(negedge clk);
        run_op(16'h7FFF, 16'd1, 16'h7FFF, 16'd0, 1'b0, 31, 1'b0);
        @(negedge clk);
        run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 31, 1'b0);

        // Abort in cycle 12 of a divide, then a clean divide after release.
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 31, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            r = int'($urandom_range(0, 9));
            case (r)
                0: begin
                    dividend = 16'($urandom);
                    divisor  = 16'($urandom);
                end
                1: begin
                    dividend = 16'($urandom) & 16'h7FFF;
                    divisor  = 16'd0;
                end
                2: begin
                    dividend = 16'h7FFF;
                    divisor  = 16'($urandom_range(1, 3));
                end
                default: begin
                    dividend = 16'($urandom) & 16'h7FFF;
                    divisor  = (r < 6) ? 16'($urandom_range(1, 40)) : 16'($urandom_range(1, 16'h3FFF));
                end
            endcase
            start = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
